cmd_tx_dbuf: RTL and testbench
==============================

Name: cmd_tx_dbuf

Overview:
- Host-to-device data buffer that sits between the application-layer data write strobe and the transport-layer outbound data port (tl_data_out / tl_data_val_out / tl_data_last_out / tl_data_strobe_in) of the command layer.
- Accepts dwords written by the application layer into a FIFO.
- On a start request, streams exactly the programmed number of dwords to the transport layer and flags the last one.
- Reports completion, abort and error status back to the command register logic.

Parameters:
- ADDR_BITS, 9, FIFO depth is 2^ADDR_BITS dwords (512).
- MAX_DWORDS, 2048, largest transfer accepted; this is the Data FIS payload limit.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  reset, asynchronous, active-low.
- al_data_in  in  32  write data from the application layer.
- al_data_val_in  in  1  write strobe; one dword per cycle.
- al_data_busy_out  out  1  FIFO full; writes are dropped while high.
- xfer_start_in  in  1  one-cycle pulse; begins a transfer of xfer_dwords_in dwords.
- xfer_dwords_in  in  12  transfer length in dwords, 1..MAX_DWORDS; sampled on xfer_start_in.
- xfer_abort_in  in  1  one-cycle pulse; terminates the transfer and flushes the FIFO.
- tl_data_out  out  32  dword to the transport layer.
- tl_data_val_out  out  1  tl_data_out is valid.
- tl_data_last_out  out  1  the current dword is the final one of the transfer.
- tl_data_strobe_in  in  1  the transport layer consumed the current dword.
- xfer_done_out  out  1  one-cycle pulse when the last dword is consumed.
- xfer_err_out  out  1  one-cycle pulse on bad length, or on a start while busy.
- xfer_aborted_out  out  1  one-cycle pulse after an abort completes.
- overflow_out  out  1  sticky: a write arrived while the FIFO was full. Cleared on an accepted start.
- strobe_err_out  out  1  sticky: a strobe arrived with tl_data_val_out low. Cleared on an accepted start.
- fifo_level_out  out  ADDR_BITS+1  dwords currently held, including the output register.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO is empty; pointers and level are 0.
  - State is IDLE.
  - All outputs are 0.
- FIFO implementation:
  - Inferred RAM with a registered read, plus a show-ahead output register.
  - A dword written in cycle N appears on tl_data_out in cycle N+2 when the FIFO was empty and the state is SEND.
  - Pointers wrap modulo 2^ADDR_BITS.
  - full = (level == 2^ADDR_BITS); empty = (level == 0).
  - A simultaneous write and read leaves level unchanged.
  - A write while full is dropped and sets overflow_out.
- Writes are accepted in every state except FLUSH, so the host may pre-fill the FIFO in IDLE.
- State IDLE:
  - xfer_start_in with 1 <= xfer_dwords_in <= MAX_DWORDS: load the remaining counter, clear the sticky flags, go to SEND.
  - xfer_start_in with a length of 0 or greater than MAX_DWORDS: pulse xfer_err_out and stay in IDLE.
- State SEND:
  - tl_data_val_out = output register valid.
  - tl_data_last_out = tl_data_val_out & (remaining == 1).
  - A strobe with val high pops one dword and decrements remaining.
  - A strobe on the last dword goes to DONE.
  - A strobe with val low is ignored and sets strobe_err_out.
  - xfer_start_in while in SEND: pulse xfer_err_out, ignore the start.
- State DONE: pulse xfer_done_out for one cycle, then go to IDLE. Surplus FIFO dwords are retained for the next transfer.
- xfer_abort_in, in any state:
  - Go to FLUSH.
  - tl_data_val_out drops in the next cycle.
- State FLUSH:
  - Reset pointers, level and the output register.
  - Next cycle: pulse xfer_aborted_out and go to IDLE.
  - Writes arriving during FLUSH are discarded without setting overflow.
- Simultaneous events:
  - Abort wins over start and over strobe.
  - A start arriving in the same cycle as a DONE pulse is treated as a start while busy (error).
- al_data_busy_out = full; it is registered, with no combinational path from the write inputs.

Decomposition:
- Shared package:
  - state encoding (IDLE, SEND, DONE, FLUSH, 2 bits);
  - the MAX_DWORDS constant;
  - the 12-bit length type.
- One sub-module: sync_fifo_sa. It is a synchronous show-ahead FIFO with parameterised depth and width, exposing level, full and empty. The FSM and counters stay in cmd_tx_dbuf.

Test Plan:
- Pre-fill 4 dwords 0xA0..0xA3, start with xfer_dwords_in=4, strobe every cycle -> tl_data_out sequence is A0,A1,A2,A3; last is asserted only with A3; xfer_done_out pulses once; level is 0.
- Start with length 3 on an empty FIFO, then write 1 dword every 3 cycles, strobe continuously -> val toggles, each dword appears 2 cycles after its write, last is asserted on the 3rd dword, no strobe_err_out.
- Write 513 dwords into an empty FIFO in IDLE -> al_data_busy_out rises after write 512, dword 513 is dropped, overflow_out=1, level=512. The next accepted start clears overflow_out.
- Start with lengths 0 and 2049 -> xfer_err_out pulses, state stays IDLE. A start issued mid-SEND -> xfer_err_out pulses, the transfer continues unchanged.
- Abort after 2 of 8 dwords of a 10-dword transfer, with a write in the same cycle -> val drops the next cycle, xfer_aborted_out pulses 2 cycles after the abort, level is 0.
- Assert rst low mid-SEND, asynchronously to clk -> all outputs go to 0 immediately, FIFO is empty, state is IDLE after release.

Source files
------------

// File: rtl/cmd_tx_dbuf_pkg.sv
// cmd_tx_dbuf_pkg: shared state encoding, length type and transfer limit
package cmd_tx_dbuf_pkg;
   typedef enum logic [1:0] {IDLE, SEND, DONE, FLUSH} state_t;
   typedef logic [11:0] len_t;
   localparam len_t MAX_DWORDS = 12'd2048;
endpackage

// File: rtl/sync_fifo_sa.sv
// sync_fifo_sa: show-ahead FIFO; the RAM read register doubles as the output register
module sync_fifo_sa #(
   parameter int ADDR_BITS = 9,
   parameter int WIDTH     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 wr,
   input  logic [WIDTH-1:0]     din,
   input  logic                 rd,
   output logic [WIDTH-1:0]     dout,
   output logic                 valid,
   output logic                 full,
   output logic                 empty,
   output logic [ADDR_BITS:0]   level
);
   logic [WIDTH-1:0] mem [2**ADDR_BITS];
   logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
   logic [ADDR_BITS:0] level_nxt;
   logic do_wr, do_pop, fetch;
   assign do_wr = wr && !full;
   assign do_pop = rd && valid;
   // RAM holds level minus the dword parked in the output register
   assign fetch = (!valid || do_pop) && (level != (ADDR_BITS+1)'(valid));
   assign level_nxt = level + (ADDR_BITS+1)'(do_wr) - (ADDR_BITS+1)'(do_pop);
   assign empty = (level == '0);
   always_ff @(posedge clk)
      if (do_wr) mem[wr_ptr] <= din;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         valid  <= 1'b0;
         full   <= 1'b0;
         dout   <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         valid  <= 1'b0;
         full   <= 1'b0;
         dout   <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + ADDR_BITS'(1);
         if (fetch) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + ADDR_BITS'(1);
         end
         valid <= fetch ? 1'b1 : (do_pop ? 1'b0 : valid);
         level <= level_nxt;
         full  <= level_nxt[ADDR_BITS];
      end
   end
endmodule

// File: rtl/cmd_tx_dbuf.sv
// cmd_tx_dbuf: host-to-device dword buffer streaming a programmed-length transfer
// to the transport layer, with done/abort/error status for the command registers
module cmd_tx_dbuf
   import cmd_tx_dbuf_pkg::*;
#(
   parameter int ADDR_BITS = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          al_data_in,
   input  logic                 al_data_val_in,
   output logic                 al_data_busy_out,
   input  logic                 xfer_start_in,
   input  logic [11:0]          xfer_dwords_in,
   input  logic                 xfer_abort_in,
   output logic [31:0]          tl_data_out,
   output logic                 tl_data_val_out,
   output logic                 tl_data_last_out,
   input  logic                 tl_data_strobe_in,
   output logic                 xfer_done_out,
   output logic                 xfer_err_out,
   output logic                 xfer_aborted_out,
   output logic                 overflow_out,
   output logic                 strobe_err_out,
   output logic [ADDR_BITS:0]   fifo_level_out
);
   state_t state, state_nxt;
   len_t remaining;
   logic fifo_valid, fifo_empty, wr, pop, len_ok, accept, bad;
   assign wr = al_data_val_in && state != FLUSH;
   assign tl_data_val_out = state == SEND && fifo_valid;
   assign tl_data_last_out = tl_data_val_out && remaining == 12'd1;
   assign pop = tl_data_val_out && tl_data_strobe_in && !fifo_empty && !xfer_abort_in;
   assign len_ok = xfer_dwords_in != '0 && xfer_dwords_in <= MAX_DWORDS;
   // abort overrides any start in the same cycle, so it is neither accepted nor an error
   assign accept = xfer_start_in && !xfer_abort_in && state == IDLE && len_ok;
   assign bad = xfer_start_in && !xfer_abort_in && !accept;
   assign xfer_done_out = state == DONE;
   sync_fifo_sa #(.ADDR_BITS(ADDR_BITS), .WIDTH(32)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (state == FLUSH),
      .wr    (wr),
      .din   (al_data_in),
      .rd    (pop),
      .dout  (tl_data_out),
      .valid (fifo_valid),
      .full  (al_data_busy_out),
      .empty (fifo_empty),
      .level (fifo_level_out)
   );
   always_comb begin
      state_nxt = state;
      state_nxt = xfer_abort_in ? FLUSH :
                  accept ? SEND :
                  (pop && remaining == 12'd1) ? DONE :
                  (state == DONE || state == FLUSH) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         remaining        <= '0;
         xfer_err_out     <= 1'b0;
         xfer_aborted_out <= 1'b0;
         overflow_out     <= 1'b0;
         strobe_err_out   <= 1'b0;
      end else begin
         state            <= state_nxt;
         remaining        <= accept ? xfer_dwords_in : (pop ? remaining - 12'd1 : remaining);
         xfer_err_out     <= bad;
         xfer_aborted_out <= state == FLUSH && state_nxt == IDLE;
         overflow_out     <= !accept && (overflow_out || (wr && al_data_busy_out));
         strobe_err_out   <= !accept && (strobe_err_out || (tl_data_strobe_in && !tl_data_val_out));
      end
   end
endmodule

// File: tb/tb_cmd_tx_dbuf.sv
// tb_cmd_tx_dbuf: directed and random stimulus checked every cycle against a queue-based model
module tb_cmd_tx_dbuf;
   localparam int DEPTH = 512;
   localparam int MAXD  = 2048;
   logic clk = 1'b0, rst = 1'b0;
   logic [31:0] al_data_in = '0;
   logic al_data_val_in = 1'b0, xfer_start_in = 1'b0, xfer_abort_in = 1'b0, tl_data_strobe_in = 1'b0;
   logic [11:0] xfer_dwords_in = '0;
   logic al_data_busy_out, tl_data_val_out, tl_data_last_out, xfer_done_out;
   logic xfer_err_out, xfer_aborted_out, overflow_out, strobe_err_out;
   logic [31:0] tl_data_out;
   logic [9:0] fifo_level_out;
   cmd_tx_dbuf dut (
      .clk(clk), .rst(rst),
      .al_data_in(al_data_in), .al_data_val_in(al_data_val_in), .al_data_busy_out(al_data_busy_out),
      .xfer_start_in(xfer_start_in), .xfer_dwords_in(xfer_dwords_in), .xfer_abort_in(xfer_abort_in),
      .tl_data_out(tl_data_out), .tl_data_val_out(tl_data_val_out), .tl_data_last_out(tl_data_last_out),
      .tl_data_strobe_in(tl_data_strobe_in), .xfer_done_out(xfer_done_out), .xfer_err_out(xfer_err_out),
      .xfer_aborted_out(xfer_aborted_out), .overflow_out(overflow_out), .strobe_err_out(strobe_err_out),
      .fifo_level_out(fifo_level_out)
   );
   always #5 clk = ~clk;
   int n_vec = 0, n_bad = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask
   // model: contents in order, each with the earliest cycle it can be presented
   typedef enum {M_IDLE, M_SEND, M_DONE, M_FLUSH} mode_t;
   mode_t mode = M_IDLE;
   int rem = 0, cyc = 0;
   bit ovf = 0, serr = 0, err_p = 0, ab_p = 0;
   logic [31:0] qd[$];
   int qr[$];
   function automatic void model_reset();
      mode = M_IDLE; rem = 0; ovf = 0; serr = 0; err_p = 0; ab_p = 0;
      qd.delete(); qr.delete();
   endfunction
   // sbm: 0 no strobe, 1 strobe, 2 strobe only when a dword is expected to be valid
   task automatic step(input bit wv, input logic [31:0] wd, input bit st, input int ln, input bit ab, input int sbm);
      bit v, sb, full, acc, pop;
      v = mode == M_SEND && qd.size() > 0 && qr[0] <= cyc;
      check("val", tl_data_val_out, v);
      if (v) check("data", tl_data_out, qd[0]);
      check("last", tl_data_last_out, v && rem == 1);
      check("done", xfer_done_out, mode == M_DONE);
      check("err", xfer_err_out, err_p);
      check("aborted", xfer_aborted_out, ab_p);
      check("overflow", overflow_out, ovf);
      check("strobe_err", strobe_err_out, serr);
      check("level", fifo_level_out, qd.size());
      check("busy", al_data_busy_out, qd.size() == DEPTH);
      sb = sbm == 1 || (sbm == 2 && v);
      al_data_val_in = wv; al_data_in = wd; xfer_start_in = st;
      xfer_dwords_in = 12'(ln); xfer_abort_in = ab; tl_data_strobe_in = sb;
      full = qd.size() == DEPTH;
      acc = st && !ab && mode == M_IDLE && ln >= 1 && ln <= MAXD;
      pop = mode == M_SEND && sb && v && !ab;
      err_p = st && !ab && !acc;
      ab_p = mode == M_FLUSH && !ab;
      ovf = !acc && (ovf || (wv && full && mode != M_FLUSH));
      serr = !acc && (serr || (sb && !v));
      if (mode == M_FLUSH) begin
         qd.delete(); qr.delete();
      end else begin
         if (pop) begin void'(qd.pop_front()); void'(qr.pop_front()); end
         if (wv && !full) begin qd.push_back(wd); qr.push_back(cyc + 2); end
      end
      if (ab) mode = M_FLUSH;
      else if (acc) begin mode = M_SEND; rem = ln; end
      else if (pop) begin rem--; if (rem == 0) mode = M_DONE; end
      else if (mode == M_DONE || mode == M_FLUSH) mode = M_IDLE;
      cyc++;
      @(negedge clk);
   endtask
   task automatic idle(input int n, input int sbm);
      repeat (n) step(0, '0, 0, 0, 0, sbm);
   endtask
   initial begin
      #1;
      check("rst_val", tl_data_val_out, 0);
      check("rst_level", fifo_level_out, 0);
      check("rst_busy", al_data_busy_out, 0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      // prefill A0..A3 and stream a 4-dword transfer
      for (int i = 0; i < 4; i++) step(1, 32'hA0 + i, 0, 0, 0, 0);
      step(0, '0, 1, 4, 0, 0);
      idle(8, 2);
      // trickle writes into a running 3-dword transfer
      step(0, '0, 1, 3, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 32'hB0 + i, 0, 0, 0, 2);
         idle(2, 2);
      end
      idle(3, 2);
      // overflow: 513 writes, then an accepted start clears the flag
      for (int i = 0; i < 513; i++) step(1, 32'h1000 + i, 0, 0, 0, 0);
      idle(2, 0);
      step(0, '0, 1, 1, 0, 0);
      idle(4, 2);
      step(0, '0, 0, 0, 1, 0);
      idle(3, 0);
      // bad lengths, then a start while busy
      step(0, '0, 1, 0, 0, 0);
      step(0, '0, 1, 2049, 0, 0);
      idle(2, 0);
      for (int i = 0; i < 5; i++) step(1, 32'hC0 + i, 0, 0, 0, 0);
      step(0, '0, 1, 5, 0, 0);
      step(0, '0, 0, 0, 0, 2);
      step(0, '0, 1, 3, 0, 2);
      idle(8, 2);
      // abort after 2 of 8 dwords of a 10-dword transfer, with a write alongside
      for (int i = 0; i < 8; i++) step(1, 32'hD0 + i, 0, 0, 0, 0);
      step(0, '0, 1, 10, 0, 0);
      idle(2, 2);
      step(1, 32'hDEAD, 0, 0, 1, 2);
      idle(4, 2);
      // asynchronous reset in the middle of a transfer
      for (int i = 0; i < 4; i++) step(1, 32'hE0 + i, 0, 0, 0, 0);
      step(0, '0, 1, 4, 0, 0);
      step(0, '0, 0, 0, 0, 2);
      al_data_val_in = 0; xfer_start_in = 0; xfer_abort_in = 0; tl_data_strobe_in = 0;
      #2 rst = 1'b0;
      #1;
      check("arst_val", tl_data_val_out, 0);
      check("arst_last", tl_data_last_out, 0);
      check("arst_data", tl_data_out, 0);
      check("arst_level", fifo_level_out, 0);
      check("arst_done", xfer_done_out, 0);
      check("arst_err", xfer_err_out, 0);
      model_reset();
      @(negedge clk); rst = 1'b1;
      step(1, 32'hF0, 0, 0, 0, 0);
      step(0, '0, 1, 1, 0, 0);
      idle(4, 2);
      // random traffic
      for (int i = 0; i < 2500; i++) begin
         int r, x, ln;
         r = $urandom_range(0, 999);
         x = $urandom_range(0, 9);
         ln = x == 0 ? 0 : x == 1 ? 2049 + $urandom_range(0, 2000) : x == 2 ? MAXD : 1 + $urandom_range(0, 23);
         step($urandom_range(0, 1) == 1, $urandom, r < 20, ln, r >= 995,
              $urandom_range(0, 9) < 7 ? 2 : $urandom_range(0, 1));
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
